// File: rtl/gate_check_pkg.sv
// gate_check_pkg
//   Shared definitions for the 2-input gate truth-table checker.
//   Truth-table bit index = {in1, in2}.
package gate_check_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/gate_truth_checker.sv
// gate_truth_checker
//   Drives a 2-input gate through vectors 00,01,10,11, holds each for SETTLE
//   cycles, samples gate_out on the last cycle and compares it with EXPECTED.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : begin a sweep (honoured only in IDLE)
//   gate_out     : output of the gate under test
//   drv_in1/2    : registered drives to the gate inputs
//   busy         : sweep in progress
//   done         : one-cycle completion pulse
//   pass         : last sweep had no mismatches (held until next start)
//   fail_mask    : bit i set when vector i mismatched (held until next start)
module gate_truth_checker
  import gate_check_pkg::*;
#(
  parameter logic [3:0]  EXPECTED = TT_OR,
  parameter int unsigned SETTLE   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       gate_out,
  output logic       drv_in1,
  output logic       drv_in2,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask
);

  if (SETTLE < 1 || SETTLE > 255) begin : g_bad_settle
    $error("gate_truth_checker: SETTLE must be in 1..255");
  end

  localparam logic [7:0] CNT_LAST = 8'(SETTLE - 1);

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_idx;
  logic [1:0] w_idx_nxt;
  logic [7:0] r_cnt;
  logic [3:0] r_fail_mask;
  logic [3:0] w_mask_upd;
  logic       r_pass;
  logic       r_drv_in1;
  logic       r_drv_in2;
  logic       w_sample;
  logic       w_miss;

  assign w_sample   = (r_state == RUN) && (r_cnt == CNT_LAST);
  // Case equality so an X/Z on gate_out counts as a mismatch in simulation.
  assign w_miss     = !(gate_out === EXPECTED[r_idx]);
  assign w_mask_upd = r_fail_mask | (w_miss ? (4'b0001 << r_idx) : 4'b0000);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_sample && (r_idx == 2'd3)) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_idx_nxt = r_idx;
    if (r_state == IDLE && start)               w_idx_nxt = 2'd0;
    else if (w_sample && (r_idx != 2'd3))       w_idx_nxt = r_idx + 2'd1;
  end

  // Datapath: counter, index, result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_cnt       <= '0;
      r_fail_mask <= '0;
      r_pass      <= 1'b0;
    end else begin
      r_idx <= w_idx_nxt;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_cnt       <= '0;
            r_fail_mask <= '0;
            r_pass      <= 1'b0;
          end
        end
        RUN: begin
          if (w_sample) begin
            r_cnt       <= '0;
            r_fail_mask <= w_mask_upd;
            // Pass uses the updated mask so the final vector's result counts.
            if (r_idx == 2'd3) r_pass <= (w_mask_upd == 4'b0000);
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Drives are registered from the next index, so during RUN they equal the
  // index register cycle for cycle while staying glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drv_in1 <= 1'b0;
      r_drv_in2 <= 1'b0;
    end else if (w_next == RUN) begin
      r_drv_in1 <= w_idx_nxt[1];
      r_drv_in2 <= w_idx_nxt[0];
    end else begin
      r_drv_in1 <= 1'b0;
      r_drv_in2 <= 1'b0;
    end
  end

  // Outputs
  always_comb begin
    busy      = (r_state == RUN);
    done      = (r_state == DONE);
    drv_in1   = r_drv_in1;
    drv_in2   = r_drv_in2;
    pass      = r_pass;
    fail_mask = r_fail_mask;
  end

endmodule

// File: tb/tb_gate_truth_checker.sv
// tb_gate_truth_checker
//   Directed bench: an OR-table checker (SETTLE=2) driven against selectable
//   gate models, and an XOR-table checker (SETTLE=1) against an XOR gate.
module tb_gate_truth_checker;
  import gate_check_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_a, gate_out_a, drv1_a, drv2_a, busy_a, done_a, pass_a;
  logic [3:0] mask_a;
  logic       start_b, gate_out_b, drv1_b, drv2_b, busy_b, done_b, pass_b;
  logic [3:0] mask_b;
  int         gate_mode;  // 0: OR, 1: AND, 2: stuck-at-0
  int         n_chk  = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  gate_truth_checker #(.EXPECTED(TT_OR), .SETTLE(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .gate_out(gate_out_a),
    .drv_in1(drv1_a), .drv_in2(drv2_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .fail_mask(mask_a)
  );

  gate_truth_checker #(.EXPECTED(TT_XOR), .SETTLE(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .gate_out(gate_out_b),
    .drv_in1(drv1_b), .drv_in2(drv2_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .fail_mask(mask_b)
  );

  always_comb begin
    case (gate_mode)
      0:       gate_out_a = drv1_a | drv2_a;
      1:       gate_out_a = drv1_a & drv2_a;
      default: gate_out_a = 1'b0;
    endcase
  end
  assign gate_out_b = drv1_b ^ drv2_b;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // One sweep on DUT A, cycles 1..11 logged at negedge (edge 0 samples start).
  task automatic sweep_a(input string tag, input bit poke,
                         input logic [3:0] exp_mask, input bit exp_pass);
    logic [21:0] drv_log;
    logic [10:0] busy_log, done_log;
    logic [3:0]  m1, m9, m11;
    logic        p1, p9, p11;
    @(negedge clk); start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      drv_log[2*(c-1) +: 2] = {drv1_a, drv2_a};
      busy_log[c-1] = busy_a;
      done_log[c-1] = done_a;
      if (c == 1)  begin m1  = mask_a; p1  = pass_a; end
      if (c == 9)  begin m9  = mask_a; p9  = pass_a; end
      if (c == 11) begin m11 = mask_a; p11 = pass_a; end
      start_a = poke && (c == 3 || c == 9);
    end
    start_a = 1'b0;
    chk({tag, ".drv"},   32'(drv_log),  32'(22'b00_00_00_11_11_10_10_01_01_00_00));
    chk({tag, ".busy"},  32'(busy_log), 32'(11'b000_1111_1111));
    chk({tag, ".done"},  32'(done_log), 32'(11'b001_0000_0000));
    chk({tag, ".mask1"}, 32'(m1),  32'h0);
    chk({tag, ".pass1"}, 32'(p1),  32'h0);
    chk({tag, ".mask9"}, 32'(m9),  32'(exp_mask));
    chk({tag, ".pass9"}, 32'(p9),  32'(exp_pass));
    chk({tag, ".mask11"}, 32'(m11), 32'(exp_mask));
    chk({tag, ".pass11"}, 32'(p11), 32'(exp_pass));
  endtask

  initial begin
    logic [5:0]  busy_b_log, done_b_log;
    logic [23:0] done_cont;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; gate_mode = 0;
    #2;
    chk("reset.a", {27'd0, drv1_a, drv2_a, busy_a, done_a, pass_a}, 32'h0);
    chk("reset.a_mask", 32'(mask_a), 32'h0);
    chk("reset.b", {23'd0, drv1_b, drv2_b, busy_b, done_b, pass_b, mask_b}, 32'h0);
    #10 rst_n = 1'b1;

    gate_mode = 0; sweep_a("or",     1'b0, 4'b0000, 1'b1);
    gate_mode = 1; sweep_a("and",    1'b0, 4'b0110, 1'b0);
    gate_mode = 2; sweep_a("stuck",  1'b0, 4'b1110, 1'b0);
    gate_mode = 0; sweep_a("rerun",  1'b0, 4'b0000, 1'b1);
    gate_mode = 1; sweep_a("ignore", 1'b1, 4'b0110, 1'b0);

    // Reset in cycle 5 of a stuck-at-0 sweep: vector 1 already failed.
    gate_mode = 2;
    @(negedge clk); start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst.drv",  32'({drv1_a, drv2_a}), 32'h2);
    chk("pre_rst.busy", 32'(busy_a), 32'h1);
    chk("pre_rst.mask", 32'(mask_a), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", {27'd0, drv1_a, drv2_a, busy_a, done_a, pass_a}, 32'h0);
    chk("async_rst.mask", 32'(mask_a), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    gate_mode = 0; sweep_a("post_rst", 1'b0, 4'b0000, 1'b1);

    // SETTLE=1 XOR checker, single pulse.
    @(negedge clk); start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      busy_b_log[c-1] = busy_b;
      done_b_log[c-1] = done_b;
      if (c == 5) begin
        chk("xor.pass", 32'(pass_b), 32'h1);
        chk("xor.mask", 32'(mask_b), 32'h0);
      end
    end
    chk("xor.busy", 32'(busy_b_log), 32'(6'b001111));
    chk("xor.done", 32'(done_b_log), 32'(6'b010000));

    // Start held high: done every 6 cycles (cycles 5, 11, 17, 23).
    @(negedge clk); start_b = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      done_cont[c-1] = done_b;
    end
    start_b = 1'b0;
    chk("xor.cont_done", 32'(done_cont), 32'h0041_0410);
    chk("xor.cont_pass", 32'(pass_b), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
